// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock behind a start/done handshake.
// Operands are extended by one bit so a single datapath serves both signed and unsigned modes.
module booth_mult_seq #(
  parameter int MCAND_W = 8,
  parameter int MPLR_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        signed_mode,
  input  logic [MCAND_W-1:0]          multiplicand,
  input  logic [MPLR_W-1:0]           multiplier,
  output logic                        busy,
  output logic                        done,
  output logic [MCAND_W+MPLR_W-1:0]   product
);

  localparam int CNT_W  = $clog2(MPLR_W + 2);
  localparam int PROD_W = MCAND_W + MPLR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: start is accepted on a rising edge whenever busy is low (IDLE or DONE);
  // done is a one-cycle pulse and product holds its value until the next done.
  logic [1:0]         state;
  logic [MCAND_W:0]   br;
  logic [MCAND_W:0]   ac;
  logic [MCAND_W:0]   ac_add;
  logic [MPLR_W:0]    qr;
  logic               qnext;
  logic [CNT_W-1:0]   cnt;
  logic [PROD_W+1:0]  shifted;
  logic               accept;
  logic               last_step;

  always_comb begin
    ac_add = ac;
    case ({qr[0], qnext})
      2'b01:   ac_add = ac + br;
      2'b10:   ac_add = ac - br;
      default: ac_add = ac;
    endcase
  end

  // Arithmetic right shift of {AC, QR}; AC's sign bit replicates.
  assign shifted   = {ac_add[MCAND_W], ac_add, qr[MPLR_W:1]};
  assign accept    = start && (state != RUN);
  assign last_step = (cnt == CNT_W'(MPLR_W));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      br      <= '0;
      ac      <= '0;
      qr      <= '0;
      qnext   <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        RUN: begin
          {ac, qr} <= shifted;
          qnext    <= qr[0];
          cnt      <= cnt + CNT_W'(1);
          if (last_step) begin
            state   <= DONE;
            product <= shifted[PROD_W-1:0];
          end
        end
        default: begin
          if (accept) begin
            br    <= signed_mode ? {multiplicand[MCAND_W-1], multiplicand} : {1'b0, multiplicand};
            qr    <= signed_mode ? {multiplier[MPLR_W-1], multiplier} : {1'b0, multiplier};
            ac    <= '0;
            qnext <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
